// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, owner codes and constants used by
// the SRAM port arbiter and its wait-state counter. The width macros fall back
// to 32 bits when the surrounding build does not provide them.
`ifndef RegDataWidth
`define RegDataWidth 32
`endif
`ifndef MemAddrWidth
`define MemAddrWidth 32
`endif
`ifndef InstAddrWidth
`define InstAddrWidth 32
`endif

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic       OWNER_INST   = 1'b0;
    localparam logic       OWNER_DATA   = 1'b1;
    localparam logic [3:0] BE_FULL_WORD = 4'hF;
    localparam int         WAIT_CNT_W   = 4;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// mem_arb_wait_counter: loadable down-counter that times the SRAM wait states.
// It parks at zero; the zero flag tells the arbiter the access is on its last cycle.
module mem_arb_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load on grant, otherwise count down while the access is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between the instruction-fetch
// port and the MEM-stage data port. Data wins arbitration, except directly after
// a data access while a fetch is waiting, so a fetch never waits behind more
// than one data access. Each access owns the SRAM for WAIT_CYCLES+1 cycles,
// followed by one DONE cycle that pulses i_valid or d_ready.
// Optional: define ARB_PERF_CNT_EN to add the perf_stall_cycles/perf_data_acc counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = `MemAddrWidth,
    parameter int DATA_W      = `RegDataWidth,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_be,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_if,
    output logic              stall_mem,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_data_acc,
`endif
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_be,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    arb_state_t        state_reg;
    logic              owner_reg;
    logic              last_was_data_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [3:0]        sram_be_reg;
    logic [DATA_W-1:0] sram_wdata_reg;
    logic              sram_we_reg;
    logic              sram_oe_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              i_valid_reg;
    logic              d_ready_reg;

    logic d_req;
    logic i_req;
    logic grant_data;
    logic grant_inst;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // A simultaneous read+write is a write: only d_we selects the strobe.
    assign d_req      = d_re | d_we;
    assign i_req      = i_ce;
    assign grant_data = d_req & ~(last_was_data_reg & i_req);
    assign grant_inst = ~grant_data & i_req;
    assign cnt_load   = (state_reg == ST_IDLE) & (grant_data | grant_inst);
    assign cnt_dec    = (state_reg == ST_ACCESS);

    mem_arb_wait_counter #(
        .W(WAIT_CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    // Arbitration FSM: grant in IDLE, drive the SRAM in ACCESS, pulse the owner in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            owner_reg         <= OWNER_INST;
            last_was_data_reg <= 1'b0;
            sram_addr_reg     <= '0;
            sram_be_reg       <= '0;
            sram_wdata_reg    <= '0;
            sram_we_reg       <= 1'b0;
            sram_oe_reg       <= 1'b0;
            i_rdata_reg       <= '0;
            d_rdata_reg       <= '0;
            i_valid_reg       <= 1'b0;
            d_ready_reg       <= 1'b0;
        end else begin
            i_valid_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_data) begin
                        owner_reg      <= OWNER_DATA;
                        sram_addr_reg  <= d_addr;
                        sram_be_reg    <= d_be;
                        sram_wdata_reg <= d_wdata;
                        sram_we_reg    <= d_we;
                        sram_oe_reg    <= ~d_we;
                        state_reg      <= ST_ACCESS;
                    end else if (grant_inst) begin
                        owner_reg      <= OWNER_INST;
                        sram_addr_reg  <= i_addr;
                        sram_be_reg    <= BE_FULL_WORD;
                        sram_wdata_reg <= '0;
                        sram_we_reg    <= 1'b0;
                        sram_oe_reg    <= 1'b1;
                        state_reg      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        // sram_oe_reg doubles as the "this access is a read" flag.
                        if (sram_oe_reg) begin
                            if (owner_reg == OWNER_DATA) begin
                                d_rdata_reg <= sram_rdata;
                            end else begin
                                i_rdata_reg <= sram_rdata;
                            end
                        end
                        i_valid_reg <= (owner_reg == OWNER_INST);
                        d_ready_reg <= (owner_reg == OWNER_DATA);
                        sram_we_reg <= 1'b0;
                        sram_oe_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_was_data_reg <= (owner_reg == OWNER_DATA);
                    state_reg         <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata    = i_rdata_reg;
    assign i_valid    = i_valid_reg;
    assign d_rdata    = d_rdata_reg;
    assign d_ready    = d_ready_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_be    = sram_be_reg;
    assign sram_wdata = sram_wdata_reg;
    assign sram_we    = sram_we_reg;
    assign sram_oe    = sram_oe_reg;

    // The pipeline holds until its own pulse arrives; a pending data access freezes everything.
    assign stall_mem = d_req & ~d_ready_reg;
    assign stall_if  = (i_ce & ~i_valid_reg) | stall_mem;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cycles_reg;
    logic [31:0] perf_data_acc_reg;

    // Free-running wrap-around counters of stalled cycles and completed data accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles_reg <= '0;
            perf_data_acc_reg     <= '0;
        end else begin
            if (stall_if | stall_mem) begin
                perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
            end
            if (d_ready_reg) begin
                perf_data_acc_reg <= perf_data_acc_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_reg;
    assign perf_data_acc     = perf_data_acc_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized rounds checked cycle by cycle
// against a transaction-level model of the arbitration and timing rules.
module tb_mem_port_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_ce = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic [31:0] sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [31:0] sram_rdata = '0;

    // zero-wait-state instance
    logic        z_d_re = 1'b0;
    logic [31:0] z_d_addr = '0;
    logic [31:0] z_sram_rdata = '0;
    logic [31:0] z_i_rdata;
    logic        z_i_valid;
    logic [31:0] z_d_rdata;
    logic        z_d_ready;
    logic        z_stall_if;
    logic        z_stall_mem;
    logic [31:0] z_sram_addr;
    logic [3:0]  z_sram_be;
    logic [31:0] z_sram_wdata;
    logic        z_sram_we;
    logic        z_sram_oe;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_data_acc, z_perf_stall_cycles, z_perf_data_acc;
`endif

    int errors = 0;
    int checks = 0;

    // model state
    bit          lwd_m = 1'b0;
    logic [31:0] exp_i_data = '0;
    logic [31:0] exp_d_data = '0;
    int          stall_cnt_m = 0;
    int          data_acc_m = 0;
    int unsigned nid = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_data_acc(perf_data_acc),
`endif
        .sram_addr(sram_addr), .sram_be(sram_be), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .i_ce(1'b0), .i_addr(32'h0), .i_rdata(z_i_rdata), .i_valid(z_i_valid),
        .d_re(z_d_re), .d_we(1'b0), .d_addr(z_d_addr), .d_be(4'hF), .d_wdata(32'h0),
        .d_rdata(z_d_rdata), .d_ready(z_d_ready),
        .stall_if(z_stall_if), .stall_mem(z_stall_mem),
`ifdef ARB_PERF_CNT_EN
        .perf_stall_cycles(z_perf_stall_cycles), .perf_data_acc(z_perf_data_acc),
`endif
        .sram_addr(z_sram_addr), .sram_be(z_sram_be), .sram_wdata(z_sram_wdata),
        .sram_we(z_sram_we), .sram_oe(z_sram_oe), .sram_rdata(z_sram_rdata)
    );

    function automatic logic [31:0] hash32(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One round: raise the requests in an IDLE cycle, follow both accesses to
    // completion, then idle one cycle. Must be entered on a falling edge.
    task automatic run_round(input bit ie, input logic [31:0] ia, input int dk,
                             input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
        bit has_d, is_wr, d_first, two, in_win, win_end, win_data;
        bit exp_oe, exp_we, exp_iv, exp_dr, exp_sm, exp_si, d_act, i_act;
        int d_pulse, i_pulse, last;
        logic [31:0] exp_a;
        logic [3:0]  exp_be;
        has_d   = (dk != 0);
        is_wr   = (dk >= 2);
        d_first = has_d && !(lwd_m && ie);
        two     = has_d && ie;
        d_pulse = -1;
        i_pulse = -1;
        if (d_first) begin
            d_pulse = W + 2;
            if (ie) i_pulse = 2 * W + 5;
        end else begin
            i_pulse = W + 2;
            if (has_d) d_pulse = 2 * W + 5;
        end
        last = (d_pulse > i_pulse) ? d_pulse : i_pulse;
        $display("round: i_ce=%0d i_addr=%h dkind=%0d d_addr=%h be=%h wdata=%h data_first=%0d",
                 ie, ia, dk, da, be, wd, d_first);
        i_ce = ie; i_addr = ia;
        d_re = (dk == 1) || (dk == 3); d_we = is_wr;
        d_addr = da; d_be = be; d_wdata = wd;
        for (int n = 0; n <= last; n++) begin
            if (n == 0) #1; else @(negedge clk);
            in_win = 1'b0; win_data = 1'b0; win_end = 1'b0;
            if (n >= 1 && n <= W + 1) begin
                in_win = 1'b1; win_data = d_first; win_end = (n == W + 1);
            end else if (two && n >= W + 4 && n <= 2 * W + 4) begin
                in_win = 1'b1; win_data = !d_first; win_end = (n == 2 * W + 4);
            end
            exp_oe = in_win && !(win_data && is_wr);
            exp_we = in_win && win_data && is_wr;
            exp_a  = win_data ? da : ia;
            exp_be = win_data ? be : 4'hF;
            exp_iv = (n == i_pulse);
            exp_dr = (n == d_pulse);
            d_act  = has_d && (n <= d_pulse);
            i_act  = ie && (n <= i_pulse);
            exp_sm = d_act && !exp_dr;
            exp_si = (i_act && !exp_iv) || exp_sm;
            checks++; if (i_valid !== exp_iv) begin errors++; $display("FAIL i_valid n=%0d: got %b expected %b", n, i_valid, exp_iv); end
            checks++; if (d_ready !== exp_dr) begin errors++; $display("FAIL d_ready n=%0d: got %b expected %b", n, d_ready, exp_dr); end
            checks++; if (stall_mem !== exp_sm) begin errors++; $display("FAIL stall_mem n=%0d: got %b expected %b", n, stall_mem, exp_sm); end
            checks++; if (stall_if !== exp_si) begin errors++; $display("FAIL stall_if n=%0d: got %b expected %b", n, stall_if, exp_si); end
            checks++; if (sram_oe !== exp_oe) begin errors++; $display("FAIL sram_oe n=%0d: got %b expected %b", n, sram_oe, exp_oe); end
            checks++; if (sram_we !== exp_we) begin errors++; $display("FAIL sram_we n=%0d: got %b expected %b", n, sram_we, exp_we); end
            if (in_win) begin
                checks++; if (sram_addr !== exp_a) begin errors++; $display("FAIL sram_addr n=%0d: got %h expected %h", n, sram_addr, exp_a); end
                checks++; if (sram_be !== exp_be) begin errors++; $display("FAIL sram_be n=%0d: got %h expected %h", n, sram_be, exp_be); end
                if (exp_we) begin
                    checks++; if (sram_wdata !== wd) begin errors++; $display("FAIL sram_wdata n=%0d: got %h expected %h", n, sram_wdata, wd); end
                end
            end
            if (exp_dr && !is_wr) begin
                checks++; if (d_rdata !== exp_d_data) begin errors++; $display("FAIL d_rdata: got %h expected %h", d_rdata, exp_d_data); end
            end
            if (exp_iv) begin
                checks++; if (i_rdata !== exp_i_data) begin errors++; $display("FAIL i_rdata: got %h expected %h", i_rdata, exp_i_data); end
            end
            if (exp_si || exp_sm) stall_cnt_m++;
            // SRAM model: a new word every cycle, so a capture in the wrong cycle shows.
            nid++;
            sram_rdata = hash32(sram_addr) ^ nid;
            if (win_end && exp_oe) begin
                if (win_data) exp_d_data = hash32(exp_a) ^ nid;
                else          exp_i_data = hash32(exp_a) ^ nid;
            end
            if (exp_dr) begin d_re = 1'b0; d_we = 1'b0; end
            if (exp_iv) i_ce = 1'b0;
        end
        lwd_m = two ? !d_first : has_d;
        if (has_d) data_acc_m++;
        @(negedge clk);
        checks++; if (i_rdata !== exp_i_data) begin errors++; $display("FAIL i_rdata_hold: got %h expected %h", i_rdata, exp_i_data); end
        checks++; if (d_rdata !== exp_d_data) begin errors++; $display("FAIL d_rdata_hold: got %h expected %h", d_rdata, exp_d_data); end
        checks++; if ({sram_oe, sram_we, i_valid, d_ready} !== 4'b0000) begin errors++; $display("FAIL idle_after_round: got %b expected 0000", {sram_oe, sram_we, i_valid, d_ready}); end
        nid++;
        sram_rdata = hash32(sram_addr) ^ nid;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if ({i_rdata, d_rdata, sram_wdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {i_rdata, d_rdata, sram_wdata}); end
        checks++; if ({sram_addr, sram_be} !== 36'h0) begin errors++; $display("FAIL reset_addr_be: got %h expected 0", {sram_addr, sram_be}); end
        checks++; if ({sram_we, sram_oe, i_valid, d_ready} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {sram_we, sram_oe, i_valid, d_ready}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({sram_oe, sram_we, stall_if, stall_mem} !== 4'b0000) begin errors++; $display("FAIL idle_after_reset: got %b expected 0000", {sram_oe, sram_we, stall_if, stall_mem}); end
        $display("reset: done");
    endtask

    task automatic test_inst_fetch();
        run_round(1'b1, 32'h100, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_simultaneous();
        run_round(1'b1, 32'h104, 2, 32'h2000, 4'b0011, 32'hDEADBEEF);
    endtask

    task automatic test_back_to_back();
        run_round(1'b1, 32'h108, 1, 32'h2004, 4'hF, 32'h0);
        run_round(1'b0, 32'h0,   1, 32'h2008, 4'hF, 32'h0);
        run_round(1'b1, 32'h10C, 1, 32'h200C, 4'hF, 32'h0);
        run_round(1'b1, 32'h110, 3, 32'h2010, 4'b1100, 32'h12345678);
    endtask

    task automatic test_reset_mid_access();
        run_round(1'b0, 32'h0, 1, 32'h80, 4'hF, 32'h0);
        i_ce = 1'b1; i_addr = 32'h300; d_re = 1'b1; d_addr = 32'h84; d_be = 4'hF;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1; i_ce = 1'b0; d_re = 1'b0;
        #1;
        checks++; if ({i_rdata, d_rdata, sram_wdata} !== 96'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", {i_rdata, d_rdata, sram_wdata}); end
        checks++; if ({sram_addr, sram_be} !== 36'h0) begin errors++; $display("FAIL midrst_addr_be: got %h expected 0", {sram_addr, sram_be}); end
        checks++; if ({sram_we, sram_oe, i_valid, d_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_strobes: got %b expected 0000", {sram_we, sram_oe, i_valid, d_ready}); end
        lwd_m = 1'b0; exp_i_data = '0; exp_d_data = '0; stall_cnt_m = 0; data_acc_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset_mid_access: released");
        run_round(1'b1, 32'h304, 1, 32'h88, 4'hF, 32'h0);
    endtask

    task automatic test_wait0();
        logic [31:0] r;
        r = $urandom;
        z_d_addr = 32'h40; z_d_re = 1'b1; z_sram_rdata = ~r;
        #1;
        checks++; if ({z_stall_mem, z_stall_if} !== 2'b11) begin errors++; $display("FAIL w0_stall_req: got %b expected 11", {z_stall_mem, z_stall_if}); end
        @(negedge clk);
        checks++; if ({z_sram_oe, z_sram_we, z_d_ready} !== 3'b100) begin errors++; $display("FAIL w0_access_strobes: got %b expected 100", {z_sram_oe, z_sram_we, z_d_ready}); end
        checks++; if ({z_sram_addr, z_sram_be, z_sram_wdata} !== {32'h40, 4'hF, 32'h0}) begin errors++; $display("FAIL w0_access_bus: got %h expected %h", {z_sram_addr, z_sram_be, z_sram_wdata}, {32'h40, 4'hF, 32'h0}); end
        z_sram_rdata = r;
        @(negedge clk);
        checks++; if ({z_d_ready, z_sram_oe, z_stall_mem, z_i_valid} !== 4'b1000) begin errors++; $display("FAIL w0_done_flags: got %b expected 1000", {z_d_ready, z_sram_oe, z_stall_mem, z_i_valid}); end
        checks++; if (z_d_rdata !== r) begin errors++; $display("FAIL w0_d_rdata: got %h expected %h", z_d_rdata, r); end
        checks++; if (z_i_rdata !== 32'h0) begin errors++; $display("FAIL w0_i_rdata: got %h expected 0", z_i_rdata); end
        z_d_re = 1'b0; z_sram_rdata = r ^ 32'h12345678;
        @(negedge clk);
        checks++; if ({z_d_ready, z_stall_if} !== 2'b00) begin errors++; $display("FAIL w0_after: got %b expected 00", {z_d_ready, z_stall_if}); end
        checks++; if (z_d_rdata !== r) begin errors++; $display("FAIL w0_d_rdata_hold: got %h expected %h", z_d_rdata, r); end
        $display("wait0: d_addr=40 rdata=%h", r);
    endtask

    task automatic test_random();
        bit ie;
        int dk;
        for (int k = 0; k < 24; k++) begin
            ie = 1'($urandom_range(0, 1));
            dk = int'($urandom_range(0, 3));
            if (!ie && dk == 0) ie = 1'b1;
            run_round(ie, $urandom & 32'hFFFF_FFFC, dk, $urandom & 32'hFFFF_FFFC,
                      4'($urandom), $urandom);
        end
    endtask

    task automatic test_perf();
`ifdef ARB_PERF_CNT_EN
        checks++; if (perf_data_acc !== 32'(data_acc_m)) begin errors++; $display("FAIL perf_data_acc: got %0d expected %0d", perf_data_acc, data_acc_m); end
        checks++; if (perf_stall_cycles !== 32'(stall_cnt_m)) begin errors++; $display("FAIL perf_stall_cycles: got %0d expected %0d", perf_stall_cycles, stall_cnt_m); end
        $display("perf: data_acc=%0d stall_cycles=%0d", perf_data_acc, perf_stall_cycles);
`endif
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_perf();
        test_inst_fetch();
        test_back_to_back();
        test_wait0();
        test_reset_mid_access();
        test_random();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
